// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler feeding the single UDP/IP frame sender.
// Validates length, pads short payloads, supervises completion.
module udp_tx_scheduler #(
  parameter int N_REQ          = 2,
  parameter int MAX_PAYLOAD    = 1472,
  parameter int MIN_PAYLOAD    = 18,
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   req_len,
  output logic [N_REQ-1:0]      grant,
  output logic [2:0]            grant_idx,
  output logic [N_REQ-1:0]      ack,
  output logic [N_REQ-1:0]      err,
  output logic                  tx_start,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic [15:0]           tx_data_length,
  output logic [15:0]           tx_total_length,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [15:0] MAX_L   = 16'(MAX_PAYLOAD);
  localparam logic [15:0] MIN_L   = 16'(MIN_PAYLOAD);
  localparam logic [15:0] GAP_END = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_END = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [2:0]       gidx_q, gidx_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             start_q, start_d;
  logic [15:0]      dlen_q, dlen_d;
  logic [15:0]      tlen_q, tlen_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      gap_q, gap_d;
  logic [15:0]      tmo_q, tmo_d;

  logic             win_found;
  logic [2:0]       win_idx;
  logic [15:0]      win_len;
  logic [15:0]      pad_len;

  // Search starts at the pointer and wraps; earliest offset wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!win_found && req[j] &&
            3'((int'(ptr_q) + i) % N_REQ) == 3'(j)) begin
          win_found = 1'b1;
          win_idx   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    win_len = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == 3'(i)) win_len = req_len[16*i +: 16];
    end
  end

  assign pad_len = (len_q < MIN_L) ? MIN_L : len_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ack_d   = '0;
    err_d   = '0;
    start_d = 1'b0;
    dlen_d  = dlen_q;
    tlen_d  = tlen_q;
    fcnt_d  = fcnt_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        if (win_found) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          gidx_d  = win_idx;
          ptr_d   = (win_idx == 3'(N_REQ-1)) ? 3'd0 : win_idx + 3'd1;
          len_d   = win_len;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (len_q == 16'd0 || len_q > MAX_L) begin
          err_d   = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          dlen_d  = pad_len + 16'd8;
          tlen_d  = pad_len + 16'd28;
          state_d = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done on the final timeout cycle still counts as success.
        if (tx_done) begin
          ack_d   = grant_q;
          fcnt_d  = fcnt_q + 16'd1;
          grant_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tmo_q == TMO_END) begin
          err_d   = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q >= GAP_END && !tx_busy) begin
          state_d = S_IDLE;
        end else if (gap_q < GAP_END) begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      dlen_q  <= '0;
      tlen_q  <= '0;
      fcnt_q  <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      start_q <= start_d;
      dlen_q  <= dlen_d;
      tlen_q  <= tlen_d;
      fcnt_q  <= fcnt_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant           = grant_q;
  assign grant_idx       = gidx_q;
  assign ack             = ack_q;
  assign err             = err_q;
  assign tx_start        = start_q;
  assign tx_data_length  = dlen_q;
  assign tx_total_length = tlen_q;
  assign frame_cnt       = fcnt_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: directed frames,
// expected events queued by the driver, popped by a monitor.
module tb_udp_tx_scheduler;

  localparam int N   = 2;
  localparam int TMO = 1000;

  localparam int K_START = 0;
  localparam int K_ACK   = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int idx;
    int dlen;
    int tlen;
    int fcnt;
  } exp_t;

  logic            clk;
  logic            clr;
  logic [N-1:0]    req;
  logic [16*N-1:0] req_len;
  logic [N-1:0]    grant;
  logic [2:0]      grant_idx;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic            tx_start;
  logic            tx_busy;
  logic            tx_done;
  logic [15:0]     tx_data_length;
  logic [15:0]     tx_total_length;
  logic [15:0]     frame_cnt;
  logic            busy;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   exp_fcnt;

  udp_tx_scheduler #(
    .N_REQ(N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .clr(clr),
    .req(req),
    .req_len(req_len),
    .grant(grant),
    .grant_idx(grant_idx),
    .ack(ack),
    .err(err),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_data_length(tx_data_length),
    .tx_total_length(tx_total_length),
    .frame_cnt(frame_cnt),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int i, input int d,
                      input int t, input int f);
    exp_t e;
    e.kind = k;
    e.idx  = i;
    e.dlen = d;
    e.tlen = t;
    e.fcnt = f;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per DUT output event.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!clr && (tx_start || (|ack) || (|err))) begin
      chk("ack_err_excl", int'(|(ack & err)), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event start=%0b ack=%b err=%b",
                 tx_start, ack, err);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == K_START) begin
          chk("start_kind", int'(tx_start), 1);
          chk("start_idx", int'(grant_idx), e.idx);
          chk("start_grant", int'(grant), 1 << e.idx);
          chk("data_len", int'(tx_data_length), e.dlen);
          chk("total_len", int'(tx_total_length), e.tlen);
        end else if (e.kind == K_ACK) begin
          chk("ack_vec", int'(ack), 1 << e.idx);
          chk("ack_fcnt", int'(frame_cnt), e.fcnt);
        end else begin
          chk("err_vec", int'(err), 1 << e.idx);
          chk("err_fcnt", int'(frame_cnt), e.fcnt);
        end
      end
    end
  end

  // dly<0 withholds tx_done; hold>0 keeps tx_busy high that many
  // cycles past the ack.
  task automatic do_frame(input int idx, input int len,
                          input int dly, input int hold);
    int p;
    int n;
    int gexp;
    bit ok;
    ok = (len != 0) && (len <= 1472);
    p  = (len < 18) ? 18 : len;
    if (ok) push(K_START, idx, p + 8, p + 28, exp_fcnt);
    if (ok && dly >= 0 && dly <= TMO) begin
      exp_fcnt++;
      push(K_ACK, idx, 0, 0, exp_fcnt);
    end else begin
      push(K_ERR, idx, 0, 0, exp_fcnt);
    end
    @(negedge clk);
    req_len[16*idx +: 16] = 16'(len);
    req[idx] = 1'b1;
    @(posedge clk);
    n = 0;
    if (ok) begin
      do begin @(posedge clk); #1; n++; end
      while (!tx_start && n < 20);
      chk("start_lat", n, 3);
      tx_busy = 1'b1;
      if (dly >= 0) begin
        repeat (dly) @(negedge clk);
        tx_done = 1'b1;
        if (hold == 0) tx_busy = 1'b0;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
      end else begin
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (!((|ack) || (|err)) && n < TMO + 20);
        chk("tmo_lat", n, TMO);
        tx_busy = 1'b0;
      end
    end else begin
      do begin @(posedge clk); #1; n++; end
      while (!(|err) && n < 20);
      chk("rej_lat", n, 2);
    end
    chk("grant_drop", int'(grant), 0);
    req[idx] = 1'b0;
    gexp = (hold > 12) ? hold : 12;
    n = 0;
    do begin
      @(negedge clk);
      if (hold > 0 && n + 1 == hold) tx_busy = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < hold + 40);
    chk("gap_len", n, gexp);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    exp_fcnt = 0;
    clr      = 1'b1;
    req      = '0;
    req_len  = '0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fcnt", int'(frame_cnt), 0);
    chk("rst_dlen", int'(tx_data_length), 0);
    @(negedge clk);
    clr = 1'b0;

    do_frame(0, 100, 200, 0);
    do_frame(0, 5, 10, 0);
    do_frame(0, 0, 10, 0);
    do_frame(1, 1473, 10, 0);
    do_frame(1, 1472, 10, 0);
    do_frame(0, 100, -1, 0);
    do_frame(0, 100, TMO, 0);
    do_frame(1, 64, 10, 30);

    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("spurious_fcnt", int'(frame_cnt), exp_fcnt);
    chk("spurious_busy", int'(busy), 0);

    // Abort mid-frame via clr, then rotate from requester 0.
    push(K_START, 0, 108, 128, exp_fcnt);
    @(negedge clk);
    req_len[15:0] = 16'd100;
    req[0] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!tx_start && n < 20);
    chk("clr_pre_start", int'(tx_start), 1);
    tx_busy = 1'b1;
    repeat (10) @(negedge clk);
    clr = 1'b1;
    req = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("clr_grant", int'(grant), 0);
    chk("clr_idx", int'(grant_idx), 0);
    chk("clr_ack_err", int'({ack, err}), 0);
    chk("clr_start", int'(tx_start), 0);
    chk("clr_lens", int'({tx_data_length, tx_total_length}), 0);
    chk("clr_fcnt", int'(frame_cnt), 0);
    chk("clr_busy", int'(busy), 0);
    @(negedge clk);
    clr = 1'b0;
    tx_busy = 1'b0;
    exp_fcnt = 0;

    for (int f = 0; f < 4; f++) begin
      push(K_START, f % 2, 72, 92, exp_fcnt);
      exp_fcnt++;
      push(K_ACK, f % 2, 0, 0, exp_fcnt);
    end
    req_len = {16'd64, 16'd64};
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      while (!tx_start && n < 60) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("rr_start", int'(tx_start), 1);
      tx_busy = 1'b1;
      repeat (5) @(negedge clk);
      tx_done = 1'b1;
      tx_busy = 1'b0;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (f == 3) req = '0;
    end
    n = 0;
    while (busy && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rr_idle", int'(busy), 0);
    chk("rr_fcnt", int'(frame_cnt), 4);
    repeat (5) @(posedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
